dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-ported 8×8 data memory between the processor's load/store path (requester 0) and a host/debug loader (requester 1). It accepts one request at a time, drives the memory port from a registered command, returns registered read data with a per-requester valid strobe, and alternates fairly under contention. It sits between the `top`-level memories and the two masters and is the only driver of the memory's `we`/address/write-data pins.

## Interface
- `AW`, 3, memory address width (8 words)
- `DW`, 8, data width
- `clk` in 1, clock
- `reset` in 1, reset, asynchronous, active-high
- `req0`, `req1` in 1, request from requester 0 (CPU) / 1 (host)
- `we0`, `we1` in 1, 1 = write, 0 = read; qualified by `reqN`
- `addr0`, `addr1` in AW, word address
- `wdata0`, `wdata1` in DW, write data
- `gnt0`, `gnt1` out 1, one-cycle pulse: command accepted
- `rvalid0`, `rvalid1` out 1, one-cycle pulse: transaction complete
- `rdata` out DW, read result, valid with `rvalidN`
- `mem_en` out 1, memory access cycle
- `mem_we` out 1, memory write enable
- `mem_addr` out AW, memory address
- `mem_wdata` out DW, memory write data
- `mem_rdata` in DW, combinational memory read data
- `busy` out 1, state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Arbitration occurs only in IDLE or RESP. If any `reqN` is high: select winner, latch winner's `we`/`addr`/`wdata` and winner ID into command register, go to ACCESS. Otherwise go to IDLE.
- ACCESS: `gntW` = 1, `mem_en` = 1, `mem_we` = latched `we`, `mem_addr`/`mem_wdata` = latched values. At the end of the cycle: read → `rdata` ← `mem_rdata`; write → `rdata` ← 0. Always go to RESP.
- RESP: `rvalidW` = 1, `rdata` is held. Arbitrate again, giving back-to-back service.
- Requester rule: hold `reqN`/`weN`/`addrN`/`wdataN` stable until `gntN`. `reqN` high during a RESP cycle counts as a new request, including from the requester just served.
- Policy: a single requester always wins. When both request, the winner is the one that is not `last_winner`. `last_winner` updates on every selection.
- `rdata` holds its value between transactions.
- Outputs are mutually exclusive: at most one `gnt` and at most one `rvalid` per cycle.

## Timing
- Reset (async assert, sync deassert to the design): state = IDLE, `last_winner` = 1 (requester 0 wins the first tie). All outputs are 0, including `rdata`. An in-flight command is discarded and no `rvalid` is issued; an interrupted write may or may not have reached memory.
- Latency: `req` sampled at edge N → `gnt` and memory access in cycle N+1 → write commits at edge N+2 → `rvalid`/`rdata` in cycle N+2.
- Throughput: one transaction per 2 cycles under continuous requests; per-requester service is one transaction per 4 cycles when both request.
- A request arriving during ACCESS waits for the RESP cycle.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined: requester 0 always wins ties, and `last_winner` is unused (tied off).
- Not defined: round-robin as above.
- Handshake and timing are identical in both builds.

## Structure
- `dmem_arb_pkg`: state enum `arb_state_t` {IDLE, ACCESS, RESP}; constants `DMEM_AW` = 3, `DMEM_DW` = 8; requester ID type.
- One sub-module, `rr_pick2`: combinational 2-way picker with inputs `req[1:0]`, `last`, and output `win`. The macro selects its fixed-priority variant.

## Test plan
- Reset, then single write: `req1`, `we1`=1, `addr1`=5, `wdata1`=0x1C → `gnt1` at cycle +1 with `mem_we`=1, `mem_addr`=5, `mem_wdata`=0x1C; `rvalid1` at cycle +2 with `rdata`=0.
- Read-back: `req0`, `we0`=0, `addr0`=5 → `gnt0` at +1; `rvalid0` at +2 with `rdata`=0x1C.
- Contention: `req0` and `req1` held high for 8 cycles after reset → grant order 0,1,0,1. With `DMEM_ARB_FIXED_PRIO_EN`: grant order 0,0,0,0.
- Back-to-back: `req0` re-asserted in the RESP cycle → next ACCESS immediately follows, with no IDLE cycle.
- Reset asserted mid-ACCESS of a write to `addr`=2 → outputs are 0 immediately; no `rvalid`; state is IDLE after release; next request is served normally.
- Idle: no requests for 10 cycles → `mem_en`=0, `busy`=0, `rdata` holds its last value.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DMEM_AW = 3;
  localparam int unsigned DMEM_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CPU  = 1'b0;
  localparam req_id_t REQ_HOST = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way winner picker; round-robin on ties unless
// DMEM_ARB_FIXED_PRIO_EN selects the fixed-priority (requester 0 first) variant.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output req_id_t    win
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = last;
  assign win = req[0] ? REQ_CPU : REQ_HOST;
`else
  always_comb begin
    win = REQ_CPU;
    if (req == 2'b11) begin
      win = ~last;
    end else if (req[1]) begin
      win = REQ_HOST;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU (0) and host loader (1).
// Tie policy is round-robin unless DMEM_ARB_FIXED_PRIO_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW = DMEM_AW,
  parameter int unsigned DW = DMEM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t    r_state;
  req_id_t       r_win;
  logic          r_gnt0, r_gnt1, r_rvalid0, r_rvalid1;
  logic          r_mem_en, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_rdata;

  req_id_t       w_win;
  req_id_t       w_last;
  logic          w_any_req;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  rr_pick2 u_pick (
    .req  ({req1, req0}),
    .last (w_last),
    .win  (w_win)
  );

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign w_last = REQ_HOST;
`else
  req_id_t r_last;

  // Reset to the host so the CPU wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= REQ_HOST;
    end else if ((r_state != ACCESS) && w_any_req) begin
      r_last <= w_win;
    end
  end

  assign w_last = r_last;
`endif

  assign w_any_req   = req0 | req1;
  assign w_sel_we    = (w_win == REQ_HOST) ? we1 : we0;
  assign w_sel_addr  = (w_win == REQ_HOST) ? addr1 : addr0;
  assign w_sel_wdata = (w_win == REQ_HOST) ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_win       <= REQ_CPU;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      unique case (r_state)
        IDLE, RESP: begin
          if (w_any_req) begin
            r_state     <= ACCESS;
            r_win       <= w_win;
            r_gnt0      <= (w_win == REQ_CPU);
            r_gnt1      <= (w_win == REQ_HOST);
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          r_state   <= RESP;
          r_rdata   <= r_mem_we ? '0 : mem_rdata;
          r_rvalid0 <= (r_win == REQ_CPU);
          r_rvalid1 <= (r_win == REQ_HOST);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata     = r_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != IDLE);

endmodule
